// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: three-channel PWM for a tri-colour LED, duties reloaded once per period
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   enable       run PWM when 1, outputs held low when 0
//   rgb          duty word: [23:16] red, [15:8] green, [7:0] blue
//   pwm_r/g/b    registered PWM outputs
//   period_start one-cycle pulse when a period begins and duties are reloaded
module rgb_pwm_driver #(
    parameter int PRESCALE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [23:0] rgb,
    output logic        pwm_r,
    output logic        pwm_g,
    output logic        pwm_b,
    output logic        period_start
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state;
    logic [PW-1:0] presc;
    logic [7:0] phase, shadow_r, shadow_g, shadow_b;
    logic tick, wrap;
    assign tick = presc == PMAX;
    assign wrap = tick && phase == 8'hFF;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            presc <= '0;
            phase <= '0;
            {shadow_r, shadow_g, shadow_b} <= '0;
            {pwm_r, pwm_g, pwm_b, period_start} <= '0;
        end else if (!enable) begin
            state <= IDLE;
            presc <= '0;
            phase <= '0;
            {shadow_r, shadow_g, shadow_b} <= rgb;
            {pwm_r, pwm_g, pwm_b, period_start} <= '0;
        end else if (state == IDLE) begin
            state <= RUN;
            presc <= '0;
            phase <= '0;
            {shadow_r, shadow_g, shadow_b} <= rgb;
            {pwm_r, pwm_g, pwm_b} <= '0;
            period_start <= 1'b1;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            phase <= tick ? phase + 8'd1 : phase;
            period_start <= wrap;
            if (wrap)
                {shadow_r, shadow_g, shadow_b} <= rgb;
            // compare uses pre-edge phase/shadow, so outputs trail phase by one cycle
            pwm_r <= phase < shadow_r;
            pwm_g <= phase < shadow_g;
            pwm_b <= phase < shadow_b;
        end
    end
endmodule

// File: tb/tb_rgb_pwm_driver.sv
// tb_rgb_pwm_driver: model-checked bench for rgb_pwm_driver at PRESCALE 2 and 4
module tb_rgb_pwm_driver;
    logic clk = 0, rst = 1, enable = 0;
    logic [23:0] rgb = 24'hFFFFFF;
    logic r2, g2, b2, ps2, r4, g4, b4, ps4;
    logic [3:0] o [2];
    logic [3:0] exp_o [2];
    int checks = 0, errors = 0;
    bit go = 0;
    int t [2];
    bit run [2];
    int duty [2][3];
    rgb_pwm_driver #(.PRESCALE(2)) d2 (.clk(clk), .rst(rst), .enable(enable), .rgb(rgb),
        .pwm_r(r2), .pwm_g(g2), .pwm_b(b2), .period_start(ps2));
    rgb_pwm_driver #(.PRESCALE(4)) d4 (.clk(clk), .rst(rst), .enable(enable), .rgb(rgb),
        .pwm_r(r4), .pwm_g(g4), .pwm_b(b4), .period_start(ps4));
    assign o[0] = {ps2, r2, g2, b2};
    assign o[1] = {ps4, r4, g4, b4};
    always #5 clk = ~clk;
    function automatic int pre(input int k);
        return k == 0 ? 2 : 4;
    endfunction
    // model: t counts cycles since the last period start; a channel is high for t in 1..duty*P
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst || !enable) begin
                run[k] = 0;
                exp_o[k] = 4'b0;
            end else begin
                if (!run[k] || t[k] == 256 * pre(k) - 1) begin
                    run[k] = 1;
                    t[k] = 0;
                    for (int c = 0; c < 3; c++) duty[k][c] = int'(rgb[23 - 8 * c -: 8]);
                end else t[k]++;
                exp_o[k][3] = t[k] == 0;
                for (int c = 0; c < 3; c++)
                    exp_o[k][2 - c] = t[k] >= 1 && t[k] <= duty[k][c] * pre(k);
            end
        end
    end
    always @(negedge clk) begin
        if (go) begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (o[k] !== exp_o[k]) begin
                    errors++;
                    $display("FAIL model_p%0d at %0t: dut {ps,r,g,b}=%b want %b", pre(k), $time, o[k], exp_o[k]);
                end
            end
        end
    end
    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", n, a, e);
        end
    endtask
    task automatic measure(input int k, input int chg, input logic [23:0] nv,
                           output int len, output int hr, output int hg, output int hb);
        int w = 0;
        len = 0; hr = 0; hg = 0; hb = 0;
        while (!o[k][3] && w < 4000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 4000) begin
            chk("period_start_timeout", 0, 1);
            return;
        end
        do begin
            @(negedge clk);
            len++;
            if (len == chg) rgb = nv;
            hr += int'(o[k][2]);
            hg += int'(o[k][1]);
            hb += int'(o[k][0]);
        end while (!o[k][3] && len < 4000);
    endtask
    initial begin
        int len, hr, hg, hb;
        @(negedge clk);
        go = 1;
        @(negedge clk);
        chk("reset_outputs", int'({o[0], o[1]}), 0);
        rst = 0;
        repeat (20) @(negedge clk);
        chk("idle_outputs", int'({o[0], o[1]}), 0);
        rgb = 24'hFF8000;
        enable = 1;
        measure(0, 0, 24'h0, len, hr, hg, hb);
        chk("p2_period_len", len, 512);
        chk("p2_red_ff", hr, 510);
        chk("p2_green_80", hg, 256);
        chk("p2_blue_00", hb, 0);
        rgb = 24'h404040;
        measure(0, 0, 24'h0, len, hr, hg, hb);
        measure(0, 200, 24'hC0C0C0, len, hr, hg, hb);
        chk("mid_old_red", hr, 128);
        chk("mid_old_blue", hb, 128);
        measure(0, 0, 24'h0, len, hr, hg, hb);
        chk("mid_new_green", hg, 384);
        chk("mid_new_blue", hb, 384);
        rgb = 24'h00FF01;
        @(negedge clk);
        measure(1, 0, 24'h0, len, hr, hg, hb);
        chk("p4_period_len", len, 1024);
        chk("bound_red_00", hr, 0);
        chk("bound_green_ff", hg, 1020);
        chk("bound_blue_01", hb, 4);
        rgb = 24'h008000;
        @(negedge clk);
        measure(0, 0, 24'h0, len, hr, hg, hb);
        repeat (50) @(negedge clk);
        chk("drop_green_before", int'(g2), 1);
        enable = 0;
        @(negedge clk);
        chk("drop_green_after", int'(g2), 0);
        enable = 1;
        measure(0, 0, 24'h0, len, hr, hg, hb);
        chk("restart_green", hg, 256);
        chk("restart_red", hr, 0);
        rgb = 24'hFFFFFF;
        repeat (600) @(negedge clk);
        chk("run_red_high", int'(r2), 1);
        rst = 1;
        @(negedge clk);
        chk("midrst_outputs", int'({o[0], o[1]}), 0);
        rst = 0;
        @(negedge clk);
        chk("midrst_restart_ps", int'({ps2, ps4}), 3);
        repeat (10) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rgb_pwm_driver.md
Name: rgb_pwm_driver

Overview:
- Downstream stage of the RGB colour converter.
- Consumes the converter's registered 24-bit rgb word and drives three PWM outputs for a tri-colour LED.
- Duty values are captured once per PWM period, so rgb changes never glitch a period in progress.
- Provides a period_start strobe for sequencing logic and benches.

Parameters:
- PRESCALE, 4, clk cycles per PWM phase step. Legal range ≥1. PWM period = 256*PRESCALE clk cycles.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- enable  input  1  run PWM when 1; outputs forced low when 0.
- rgb  input  24  colour word: [23:16]=red duty, [15:8]=green duty, [7:0]=blue duty.
- pwm_r  output  1  red PWM, registered.
- pwm_g  output  1  green PWM, registered.
- pwm_b  output  1  blue PWM, registered.
- period_start  output  1  one-cycle pulse when a new period begins and duties are reloaded.

Behaviour:
- Reset (rst=1 at a clk edge; overrides everything, including mid-period):
  - state=IDLE, presc=0, phase=0, shadow_r/g/b=0.
  - pwm_r/g/b=0, period_start=0.
- Internal registers:
  - presc: counter of width clog2(PRESCALE), minimum 1 bit.
  - phase: 8-bit counter.
  - shadow_r, shadow_g, shadow_b: 8-bit duty registers.
- State IDLE (enable=0):
  - presc=0, phase=0, pwm_*=0, period_start=0.
  - shadow_* <= rgb every cycle.
- IDLE->RUN on an edge where enable=1:
  - shadow_* <= rgb; period_start <= 1; presc=0; phase=0; pwm_* <= 0.
- State RUN, each edge:
  - If presc==PRESCALE-1: presc <= 0, phase <= phase+1 (8-bit, 255 wraps to 0). Otherwise presc <= presc+1.
  - On the tick where phase==255 and presc==PRESCALE-1: shadow_* <= rgb, period_start <= 1. Otherwise period_start <= 0.
  - pwm_x <= (phase < shadow_x), an unsigned compare of current register values. Outputs therefore lag phase by one cycle.
- RUN->IDLE on an edge where enable=0:
  - pwm_* <= 0 on that edge; counters cleared as in IDLE.
  - No partial period is completed.
- Duty arithmetic, per period:
  - High time = shadow_x*PRESCALE cycles; low time = (256-shadow_x)*PRESCALE cycles.
  - Duty 0 gives constant 0.
  - Duty 255 gives high for all but PRESCALE cycles. 100% is not reachable, by design.
- Within each period, high time is contiguous and begins one cycle after period_start.
- An rgb change mid-period has no effect until the next period_start.
- enable toggling:
  - enable dropping and rising on consecutive edges restarts the period at phase 0 with a fresh period_start.
  - Held rgb values are re-sampled at restart.
- PRESCALE=1: presc is constant 0 and phase steps every cycle.
- Steady run: period_start occurs exactly every 256*PRESCALE cycles.

Test Plan:
- Reset and idle: rst=1 for 2 cycles, then rst=0, enable=0, rgb=24'hFFFFFF for 20 cycles -> pwm_r/g/b=0 and period_start=0 throughout.
- Duty measurement (PRESCALE=2): rgb=24'hFF8000, enable rises.
  - period_start pulses at first edge, then every 512 cycles.
  - Per period: pwm_r high 510 cycles, pwm_g high 256 cycles, pwm_b high 0 cycles.
  - Highs start one cycle after period_start.
- Mid-period update: running with rgb=24'h404040, change to 24'hC0C0C0 at phase≈100.
  - Current period still shows 64*PRESCALE high cycles per channel.
  - Next period (after period_start) shows 192*PRESCALE.
- Boundary duties: rgb=24'h00FF01 (PRESCALE=4).
  - red never high.
  - green low exactly 4 cycles per 1024-cycle period.
  - blue high exactly 4 cycles.
- Enable drop: deassert enable mid-period while pwm_g=1 -> pwm_g=0 on the next edge. Re-assert -> period_start pulse and phase restarts (full-length green high time).
- Reset mid-operation: rst=1 for one cycle during RUN with outputs high -> all outputs 0 next edge, state IDLE. With enable still 1, restart with period_start on the first edge after rst falls.
